stall_unit: RTL
===============

STALL_UNIT -- requirements
Module: stall_unit

Interface
REQ-001 SHALL have ports, clock and reset first, as listed in REQ-002 through REQ-011; one clock, reset asynchronous active-high.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 mem_read_EX  in  1  instruction in EX is a load; rd_EX  in  rv32i_reg  its destination register.
REQ-005 rs1_ID, rs2_ID  in  rv32i_reg  ID-stage sources; rs1_used_ID, rs2_used_ID  in  1  the source is actually read.
REQ-006 br_taken_EX  in  1  EX resolved a taken branch or jump (redirect).
REQ-007 imem_read, imem_resp  in  1 each  instruction-memory request and completion.
REQ-008 dmem_read, dmem_write, dmem_resp  in  1 each  data-memory request (MEM stage) and completion.
REQ-009 perf_clear  in  1  synchronous clear of the performance counters.
REQ-010 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipeline register enables.
REQ-011 flush_if_id, flush_id_ex  out  1 each  load a NOP into that register; stall_cnt, bubble_cnt, flush_cnt  out  32 each  counters; state_o  out  1  current FSM state.

Function
REQ-012 mem_stall SHALL be (imem_read && !imem_resp) || ((dmem_read || dmem_write) && !dmem_resp).
REQ-013 load_use SHALL be mem_read_EX && rd_EX != 0 && ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX)).
REQ-014 Priority SHALL be: rst > mem_stall > br_taken_EX > load_use > normal; all outputs combinational (Mealy) from the current inputs and state.
REQ-015 mem_stall SHALL drive all five load_* to 0 and both flush_* to 0 in the same cycle.
REQ-016 br_taken_EX without mem_stall SHALL drive all load_* to 1 and flush_if_id = flush_id_ex = 1; a coincident load_use is ignored.
REQ-017 load_use alone SHALL drive load_pc = load_if_id = 0, load_id_ex = load_ex_mem = load_mem_wb = 1, flush_id_ex = 1 (exactly one bubble), flush_if_id = 0.
REQ-018 Otherwise all load_* SHALL be 1 and all flush_* 0.
REQ-019 The FSM SHALL have states RUN (state_o = 0) and MEM_WAIT (state_o = 1).
REQ-020 RUN -> MEM_WAIT when mem_stall = 1; MEM_WAIT -> RUN on the first cycle mem_stall = 0; otherwise the FSM holds its state.
REQ-021 In MEM_WAIT, a load_use or br_taken_EX still present on the release cycle SHALL be acted on in that cycle per REQ-016/017; it is neither lost nor applied twice.
REQ-022 stall_cnt SHALL increment each cycle mem_stall = 1; bubble_cnt each cycle REQ-017 applies; flush_cnt each cycle REQ-016 applies.
REQ-023 Counters SHALL saturate at 32'hFFFF_FFFF with no wrap.
REQ-024 perf_clear SHALL zero all three counters on the next edge and take precedence over same-cycle increments; it has no effect on the FSM or the load/flush outputs.

Reset
REQ-025 While rst = 1: FSM = RUN, all counters 0, all load_* = 0, all flush_* = 1.
REQ-026 Reset asserted mid-stall SHALL return the FSM to RUN immediately, regardless of outstanding memory responses.
REQ-027 The first edge after rst deasserts SHALL see normal REQ-014 behaviour.

Structure
REQ-028 rv32i_reg and the FSM state enum (RUN, MEM_WAIT) SHALL live in the shared rv32i_types package.
REQ-029 One sub-module, sat_counter32 (increment, clear, saturate), SHALL be instantiated three times.

Verification
REQ-030 rd_EX = 5, mem_read_EX = 1, rs2_ID = 5, rs2_used_ID = 1 -> exactly one cycle with load_pc = 0 and flush_id_ex = 1; bubble_cnt = 1.
REQ-031 Same as REQ-030 but rd_EX = 0, or rs1_ID = 5 with rs1_used_ID = 0 -> no stall; bubble_cnt unchanged.
REQ-032 dmem_read = 1, dmem_resp low for 4 cycles -> all load_* = 0 for 4 cycles, state_o = 1, stall_cnt = 4; RUN on the 5th cycle.
REQ-033 br_taken_EX and load_use together -> flush_if_id = flush_id_ex = 1, all load_* = 1; flush_cnt +1, bubble_cnt +0.
REQ-034 imem stall of 3 cycles overlapping br_taken_EX -> no flush during the stall; a single flush on the release cycle; flush_cnt = 1.
REQ-035 rst pulsed during MEM_WAIT -> state_o = 0 and all counters 0 asynchronously; stall_cnt preset near 32'hFFFF_FFFF saturates; perf_clear coincident with an increment -> counter = 0.

Source files
------------

// File: rtl/stall_unit_pkg.sv
// rv32i_types: shared register-index type, stall FSM states and counter limit.
package rv32i_types;
    typedef logic [4:0] rv32i_reg;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} stall_state_e;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/stall_unit_if.sv
// stall_unit_if: hazard inputs, memory handshakes and pipeline controls of the stall unit.
interface stall_unit_if;
    import rv32i_types::*;
    logic mem_read_EX;
    rv32i_reg rd_EX, rs1_ID, rs2_ID;
    logic rs1_used_ID, rs2_used_ID;
    logic br_taken_EX;
    logic imem_read, imem_resp;
    logic dmem_read, dmem_write, dmem_resp;
    logic perf_clear;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex;
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
    logic state_o;
    modport master (
        output mem_read_EX, rd_EX, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, br_taken_EX,
               imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, perf_clear,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, stall_cnt, bubble_cnt, flush_cnt, state_o
    );
    modport slave (
        input  mem_read_EX, rd_EX, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, br_taken_EX,
               imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, perf_clear,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, stall_cnt, bubble_cnt, flush_cnt, state_o
    );
endinterface

// File: rtl/stall_unit_sat_counter32.sv
// sat_counter32: 32-bit event counter with synchronous clear and saturation at all-ones.
module sat_counter32
    import rv32i_types::*;
#(
    parameter logic [31:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);
    logic [31:0] cnt_q, cnt_d;
    // clear wins over a same-cycle increment
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != CNT_MAX) ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= RST_VAL;
        else     cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/stall_unit.sv
// stall_unit: pipeline stall/flush control for memory waits, redirects and load-use hazards.
module stall_unit
    import rv32i_types::*;
(
    input logic   clk,
    input logic   rst,
    stall_unit_if.slave bus
);
    stall_state_e state_q, state_d;
    logic mem_stall, load_use, br_act, lu_act, hold_front, stop_all;
    always_comb begin
        mem_stall = (bus.imem_read && !bus.imem_resp) ||
                    ((bus.dmem_read || bus.dmem_write) && !bus.dmem_resp);
        load_use  = bus.mem_read_EX && bus.rd_EX != '0 &&
                    ((bus.rs1_used_ID && bus.rs1_ID == bus.rd_EX) ||
                     (bus.rs2_used_ID && bus.rs2_ID == bus.rd_EX));
        state_d    = state_q;
        state_d    = mem_stall ? MEM_WAIT : RUN;
        br_act     = bus.br_taken_EX && !mem_stall;
        lu_act     = load_use && !mem_stall && !bus.br_taken_EX;
        stop_all   = rst || mem_stall;
        hold_front = stop_all || lu_act;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end
    assign bus.load_pc     = !hold_front;
    assign bus.load_if_id  = !hold_front;
    assign bus.load_id_ex  = !stop_all;
    assign bus.load_ex_mem = !stop_all;
    assign bus.load_mem_wb = !stop_all;
    assign bus.flush_if_id = rst || br_act;
    assign bus.flush_id_ex = rst || br_act || lu_act;
    assign bus.state_o     = state_q;
    sat_counter32 u_stall_cnt (
        .clk(clk), .rst(rst), .clr_i(bus.perf_clear), .inc_i(mem_stall), .cnt_o(bus.stall_cnt)
    );
    sat_counter32 u_bubble_cnt (
        .clk(clk), .rst(rst), .clr_i(bus.perf_clear), .inc_i(lu_act), .cnt_o(bus.bubble_cnt)
    );
    sat_counter32 u_flush_cnt (
        .clk(clk), .rst(rst), .clr_i(bus.perf_clear), .inc_i(br_act), .cnt_o(bus.flush_cnt)
    );
endmodule
